// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared definitions for the direct-mapped cache and its refill
//               controller: default geometry, derived field widths, refill
//               FSM state encoding and byte-address field extraction.
//               Address layout (MSB..LSB): tag | index | word offset | byte.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int LINES          = 8;
    localparam int WORDS_PER_LINE = 4;

    localparam int INDEX_W = $clog2(LINES);
    localparam int WOFF_W  = $clog2(WORDS_PER_LINE);
    localparam int TAG_W   = ADDR_W - INDEX_W - WOFF_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } refill_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[WOFF_W+2 +: INDEX_W];
    endfunction

    function automatic logic [WOFF_W-1:0] addr_woff(input logic [ADDR_W-1:0] a);
        return a[2 +: WOFF_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/refill_word_ctr.sv
`default_nettype none
// ============================================================================
// Module      : refill_word_ctr
// Description : Word counter for a line refill. Loads a start offset, counts
//               up modulo the line length and flags the final word of the
//               line, which is the word just before the start offset.
// Ports       : clk, rst_n   - clock / async active-low reset
//               load_i       - load start_i into counter and start register
//               start_i      - first word offset of the refill
//               inc_i        - advance to the next word (wraps)
//               k_o          - current word offset
//               last_o       - k_o is the final word of this refill
// Revision    : 1.0 - initial release
// ============================================================================
module refill_word_ctr #(
    parameter int WOFF_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WOFF_W-1:0] start_i,
    input  logic              inc_i,
    output logic [WOFF_W-1:0] k_o,
    output logic              last_o
);

    logic [WOFF_W-1:0] k_q;
    logic [WOFF_W-1:0] start_q;
    logic [WOFF_W-1:0] k_inc;

    // Line length is a power of two, so the natural overflow of the
    // WOFF_W-bit adder is the modulo wrap.
    assign k_inc = k_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            start_q <= '0;
        end else if (load_i) begin
            k_q     <= start_i;
            start_q <= start_i;
        end else if (inc_i) begin
            k_q     <= k_inc;
        end
    end

    // The refill has covered every word once the next word would be the start.
    assign last_o = (k_inc == start_q);
    assign k_o    = k_q;

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Miss handler behind the direct-mapped cache. Fetches a whole
//               line from memory one word per beat, writes each word into the
//               data array, forwards the requested word as it arrives and
//               finally writes the tag/valid entry.
// Build macro : CRITICAL_WORD_FIRST_EN - when defined the fetch starts at the
//               requested word and wraps; otherwise words 0..N-1 in order.
// Ports       : miss_valid/miss_addr/miss_ready - miss handshake from cache
//               mem_req/mem_addr/mem_rvalid/mem_rdata - word reads to memory
//               line_we/line_index/line_woff/line_wdata - data array write
//               tag_we/line_tag - tag array write (sets valid)
//               fwd_valid/fwd_data - requested word to the cache read port
//               refill_done - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int ADDR_W         = cache_pkg::ADDR_W,
    parameter int DATA_W         = cache_pkg::DATA_W,
    parameter int LINES          = cache_pkg::LINES,
    parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
    parameter int INDEX_W        = $clog2(LINES),
    parameter int WOFF_W         = $clog2(WORDS_PER_LINE),
    parameter int TAG_W          = ADDR_W - INDEX_W - WOFF_W - 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               miss_valid,
    input  logic [ADDR_W-1:0]  miss_addr,
    output logic               miss_ready,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               line_we,
    output logic [INDEX_W-1:0] line_index,
    output logic [WOFF_W-1:0]  line_woff,
    output logic [DATA_W-1:0]  line_wdata,
    output logic               tag_we,
    output logic [TAG_W-1:0]   line_tag,
    output logic               fwd_valid,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               refill_done
);

    import cache_pkg::*;

    refill_state_e      state_q, state_d;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic [WOFF_W-1:0]  rw_q;

    logic               accept;
    logic               ctr_inc;
    logic [WOFF_W-1:0]  ctr_start;
    logic [WOFF_W-1:0]  k;
    logic               k_last;

    // Byte-select bits never influence a word-granular refill.
    logic               unused_byte_bits;
    assign unused_byte_bits = ^miss_addr[1:0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign ctr_start = miss_addr[2 +: WOFF_W];
`else
    assign ctr_start = '0;
`endif

    refill_word_ctr #(
        .WOFF_W (WOFF_W)
    ) u_word_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .start_i (ctr_start),
        .inc_i   (ctr_inc),
        .k_o     (k),
        .last_o  (k_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            rw_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q <= miss_addr[ADDR_W-1 -: TAG_W];
                idx_q <= miss_addr[WOFF_W+2 +: INDEX_W];
                rw_q  <= miss_addr[2 +: WOFF_W];
            end
        end
    end

    // The tag/index of the line in flight are presented continuously; the
    // write strobes alone qualify them.
    assign line_index = idx_q;
    assign line_tag   = tag_q;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        ctr_inc     = 1'b0;
        miss_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        line_we     = 1'b0;
        line_woff   = '0;
        line_wdata  = '0;
        tag_we      = 1'b0;
        fwd_valid   = 1'b0;
        fwd_data    = '0;
        refill_done = 1'b0;

        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, idx_q, k, 2'b00};
                if (mem_rvalid) begin
                    line_we    = 1'b1;
                    line_woff  = k;
                    line_wdata = mem_rdata;
                    ctr_inc    = 1'b1;
                    if (k == rw_q) begin
                        fwd_valid = 1'b1;
                        fwd_data  = mem_rdata;
                    end
                    if (k_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                tag_we      = 1'b1;
                refill_done = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling stage directly downstream of the direct-mapped cache (dm_cache).
- On a miss, it fetches the whole line from main memory one word at a time and writes each word into the cache data array.
- At the end, it writes the tag/valid entry for the line.
- It forwards the originally requested word to the cache read port as soon as that word arrives.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
LINES, 8, cache lines (power of 2); INDEX_W = log2(LINES)
WORDS_PER_LINE, 4, words per line (power of 2, >=2); WOFF_W = log2(WORDS_PER_LINE)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  cache reports a miss
miss_addr  in  ADDR_W  byte address that missed
miss_ready  out  1  controller idle, accepts miss
mem_req  out  1  word read request to memory
mem_addr  out  ADDR_W  word-aligned memory address (bits [1:0]=0)
mem_rvalid  in  1  memory returns data for the outstanding request
mem_rdata  in  DATA_W  memory read data
line_we  out  1  write one word into cache data array
line_index  out  INDEX_W  cache line being refilled
line_woff  out  WOFF_W  word offset within line
line_wdata  out  DATA_W  word to write
tag_we  out  1  write tag and set valid for line_index
line_tag  out  ADDR_W-INDEX_W-WOFF_W-2  tag to write
fwd_valid  out  1  requested word available, one-cycle pulse
fwd_data  out  DATA_W  requested word
refill_done  out  1  one-cycle pulse, refill complete

Behaviour:
- Address split: [1:0] byte, [WOFF_W+1:2] word offset, next INDEX_W bits index, remainder tag.
- Reset (async, rst_n=0):
  - State IDLE, miss_ready=1.
  - All other outputs 0; word counter 0; mem_req dropped immediately.
  - Reset mid-refill aborts the refill; tag_we never fires, so the line stays invalid.
- States:
  - IDLE:
    - miss_ready=1.
    - miss_valid=1 at a clock edge latches the tag, index and requested word offset (rw), sets counter k=first word, goes to FETCH.
  - FETCH:
    - mem_req=1; mem_addr={tag,index,k,2'b00}.
    - mem_addr is held stable while waiting.
    - On a cycle with mem_rvalid=1: line_we=1 combinationally that cycle, with line_index, line_woff=k, line_wdata=mem_rdata.
    - If k==rw: fwd_valid=1 and fwd_data=mem_rdata in the same cycle.
    - If k is the last word, go to DONE; otherwise advance k and stay in FETCH.
    - mem_req stays high across back-to-back words: the memory may return one word per cycle.
  - DONE:
    - tag_we=1, line_tag=latched tag, refill_done=1 for exactly one cycle.
    - Next state IDLE.
- Word order: k starts at 0, increments, and ends at WORDS_PER_LINE-1.
- Latency: miss_valid accepted at edge N gives mem_req at N+1. With zero-wait memory (mem_rvalid in the same cycle as mem_req), refill_done occurs in cycle N+WORDS_PER_LINE+1.
- Boundary conditions:
  - miss_valid while not IDLE is ignored (miss_ready=0); the cache must hold it until it is accepted.
  - mem_rvalid outside FETCH is ignored.
  - miss_addr bits [1:0] are ignored.
  - A miss to the same index as the just-finished refill is legal and is accepted the cycle after DONE.
  - The counter wraps modulo WORDS_PER_LINE.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined:
  - k starts at rw and increments modulo WORDS_PER_LINE.
  - The fetch ends after WORDS_PER_LINE words, at word (rw-1) mod WORDS_PER_LINE.
  - fwd_valid therefore fires on the first mem_rvalid of the refill.
- Undefined: linear order 0..WORDS_PER_LINE-1 as above.
- Total refill latency is identical in both builds.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W/DATA_W/LINES/WORDS_PER_LINE defaults.
  - Derived widths INDEX_W, WOFF_W, TAG_W.
  - State enum {IDLE, FETCH, DONE}.
  - Address-field extraction functions (tag/index/woff of an address). dm_cache uses the same functions.
- One natural sub-module: refill_word_ctr.
  - Holds start offset, wrap-around increment and last-word detect.
  - Inputs: load, start, inc. Outputs: k, last.

Test Plan:
- Reset in IDLE: rst_n=0 -> miss_ready=1, mem_req=0, line_we=0, tag_we=0, fwd_valid=0, refill_done=0.
- Zero-wait refill: miss_addr=32'h00000014 with mem_rvalid always 1 and mem_rdata=addr.
  - Expected: mem_addr sequence 10,14,18,1C.
  - line_woff 0..3.
  - fwd_valid with fwd_data=32'h14 on the second word.
  - tag_we with line_index=1 and line_tag=0.
  - refill_done 5 cycles after acceptance.
- Wait states: same miss with mem_rvalid asserted every third cycle -> mem_addr stable between beats; exactly 4 line_we pulses; one fwd_valid.
- Miss while busy: second miss_valid (32'h10000020) during FETCH -> miss_ready=0 and ignored. It is accepted the cycle after DONE, and the next refill has line_index=2 and line_tag=25'h0200000.
- Reset mid-refill: rst_n low after 2 words -> mem_req drops immediately; no tag_we or refill_done; IDLE after release.
- CRITICAL_WORD_FIRST_EN build with miss_addr=32'h0000000C -> mem_addr order 0C,00,04,08; fwd_valid on the first beat.
